// File: rtl/apb_node_pkg.sv
// apb_node_pkg: shared state encoding and default SoC peripheral address map
package apb_node_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  localparam int NB_MASTER_DEF = 9;
  // index order: UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, debug
  localparam logic [NB_MASTER_DEF-1:0][31:0] DEF_START = {
    32'h1A11_0000, 32'h1A10_7000, 32'h1A10_6000, 32'h1A10_5000, 32'h1A10_4000,
    32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000};
  localparam logic [NB_MASTER_DEF-1:0][31:0] DEF_END = {
    32'h1A11_7FFF, 32'h1A10_7FFF, 32'h1A10_6FFF, 32'h1A10_5FFF, 32'h1A10_4FFF,
    32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF};
endpackage

// File: rtl/apb_addr_dec.sv
// apb_addr_dec: inclusive-range address decode with lowest-index priority
module apb_addr_dec #(
  parameter int NB_MASTER  = 9,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0] start_addr,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0] end_addr,
  output logic [NB_MASTER-1:0]                 hit_vec,
  output logic                                 hit,
  output logic [IDX_WIDTH-1:0]                 idx
);
  // scanning downwards lets the lowest matching index overwrite the others
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--)
      if (start_addr[i] <= addr && addr <= end_addr[i]) begin
        hit = 1'b1;
        idx = IDX_WIDTH'(i);
      end
    hit_vec = hit ? NB_MASTER'(1) << idx : '0;
  end
endmodule

// File: rtl/apb_node_to.sv
// apb_node_to: registered APB 1-to-N demux with programmable map, decode error
// response and per-transfer timeout
module apb_node_to
  import apb_node_pkg::*;
#(
  parameter int          NB_MASTER      = NB_MASTER_DEF,
  parameter int          APB_ADDR_WIDTH = 32,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hBADA_CCE5
) (
  input  logic                                     HCLK,
  input  logic                                     HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]                s_paddr,
  input  logic [APB_DATA_WIDTH-1:0]                s_pwdata,
  input  logic                                     s_pwrite,
  input  logic                                     s_psel,
  input  logic                                     s_penable,
  output logic [APB_DATA_WIDTH-1:0]                s_prdata,
  output logic                                     s_pready,
  output logic                                     s_pslverr,
  output logic [APB_ADDR_WIDTH-1:0]                m_paddr,
  output logic [APB_DATA_WIDTH-1:0]                m_pwdata,
  output logic                                     m_pwrite,
  output logic [NB_MASTER-1:0]                     m_psel,
  output logic                                     m_penable,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] m_prdata,
  input  logic [NB_MASTER-1:0]                     m_pready,
  input  logic [NB_MASTER-1:0]                     m_pslverr,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                                     timeout_o
);
  localparam int IW = NB_MASTER > 1 ? $clog2(NB_MASTER) : 1;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [APB_DATA_WIDTH-1:0] ERR = APB_DATA_WIDTH'(ERR_RDATA);
  state_e                  state;
  logic [IW-1:0]           idx, dec_idx;
  logic [NB_MASTER-1:0]    dec_vec;
  logic                    dec_hit;
  logic [CW-1:0]           cnt;
  apb_addr_dec #(.NB_MASTER(NB_MASTER), .ADDR_WIDTH(APB_ADDR_WIDTH), .IDX_WIDTH(IW)) u_dec (
    .addr(s_paddr), .start_addr(start_addr_i), .end_addr(end_addr_i),
    .hit_vec(dec_vec), .hit(dec_hit), .idx(dec_idx)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      m_pwrite  <= 1'b0;
      m_psel    <= '0;
      m_penable <= 1'b0;
      s_prdata  <= '0;
      s_pready  <= 1'b0;
      s_pslverr <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      s_pready  <= 1'b0;
      s_pslverr <= 1'b0;
      timeout_o <= 1'b0;
      unique case (state)
        IDLE:
          if (s_psel && !s_penable) begin
            m_paddr  <= s_paddr;
            m_pwdata <= s_pwdata;
            m_pwrite <= s_pwrite;
            idx      <= dec_idx;
            if (dec_hit) begin
              m_psel <= dec_vec;
              state  <= SETUP;
            end else begin
              s_prdata  <= ERR;
              s_pslverr <= 1'b1;
              s_pready  <= 1'b1;
              state     <= RESP;
            end
          end
        SETUP: begin
          m_penable <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (m_pready[idx]) begin
            m_psel    <= '0;
            m_penable <= 1'b0;
            s_prdata  <= m_prdata[idx];
            s_pslverr <= m_pslverr[idx];
            s_pready  <= 1'b1;
            state     <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            m_psel    <= '0;
            m_penable <= 1'b0;
            s_prdata  <= ERR;
            s_pslverr <= 1'b1;
            s_pready  <= 1'b1;
            timeout_o <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_node_to.sv
// tb_apb_node_to: randomized and directed transfers against a latency/response model
module tb_apb_node_to;
  import apb_node_pkg::*;
  localparam int TO = 8;
  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [31:0]       s_paddr = '0, s_pwdata = '0;
  logic              s_pwrite = 1'b0, s_psel = 1'b0, s_penable = 1'b0;
  logic [31:0]       s_prdata;
  logic              s_pready, s_pslverr;
  logic [31:0]       m_paddr, m_pwdata;
  logic              m_pwrite, m_penable, timeout_o;
  logic [8:0]        m_psel, m_pready, m_pslverr;
  logic [8:0][31:0]  m_prdata;
  logic [8:0][31:0]  st = DEF_START, en = DEF_END;
  int                slv_wait = 0, acc_cnt = 0;
  logic [31:0]       slv_rdata = '0;
  logic              slv_err = 1'b0;
  int                checks = 0, failures = 0;

  always #5 HCLK = ~HCLK;

  apb_node_to #(.TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite), .s_psel(s_psel),
    .s_penable(s_penable), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite), .m_psel(m_psel),
    .m_penable(m_penable), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .start_addr_i(st), .end_addr_i(en), .timeout_o(timeout_o)
  );

  // slave model: the selected port answers after slv_wait ACCESS wait states
  always @(posedge HCLK) acc_cnt <= m_penable ? acc_cnt + 1 : 0;
  assign m_pready  = m_psel & {9{m_penable && acc_cnt >= slv_wait}};
  assign m_pslverr = {9{slv_err}};
  always_comb for (int i = 0; i < 9; i++) m_prdata[i] = slv_rdata ^ 32'(i);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lookup(input logic [31:0] a);
    for (int i = 0; i < 9; i++) if (st[i] <= a && a <= en[i]) return i;
    return -1;
  endfunction

  // starts in the cycle it is called (caller sits #1 after a posedge) and
  // returns #1 into the cycle after the response, with the upstream idle
  task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic wr, input int w, input logic [31:0] rd, input logic e);
    int p = lookup(a);
    bit tmo = p >= 0 && w >= TO;
    int exp_lat = p < 0 ? 1 : tmo ? 2 + TO : 3 + w;
    int exp_selc = p < 0 ? 0 : tmo ? 1 + TO : 2 + w;
    logic [8:0] exp_sel = p < 0 ? 9'b0 : 9'b1 << p;
    logic [31:0] exp_rd = (p < 0 || tmo) ? 32'hBADA_CCE5 : rd ^ 32'(p);
    logic exp_err = p < 0 || tmo ? 1'b1 : e;
    int lat = 1, selc = 0, toc = 0, bad = 0;
    slv_wait = w; slv_rdata = rd; slv_err = e;
    s_paddr = a; s_pwdata = wd; s_pwrite = wr; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge HCLK); #1;
    s_penable = 1'b1;
    while (!s_pready && lat < 40) begin
      if (m_psel === exp_sel && exp_sel != 0) selc++;
      else if (m_psel !== 9'b0) bad++;
      if (m_psel !== 9'b0 && (m_pwdata !== wd || m_paddr !== a || m_pwrite !== wr)) bad++;
      if (timeout_o === 1'b1) toc++;
      @(posedge HCLK); #1;
      lat++;
    end
    if (timeout_o === 1'b1) toc++;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".prdata"}, s_prdata, exp_rd);
    chk({tag, ".pslverr"}, 32'(s_pslverr), 32'(exp_err));
    chk({tag, ".psel_cycles"}, selc, exp_selc);
    chk({tag, ".timeout_pulses"}, toc, tmo ? 1 : 0);
    chk({tag, ".bus_stable"}, bad, 0);
    @(posedge HCLK); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    chk({tag, ".pready_one_cycle"}, {s_pready, timeout_o}, 0);
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst.psel", m_psel, 0);
    chk("rst.penable_pready", {m_penable, s_pready, s_pslverr, timeout_o}, 0);
    chk("rst.data", s_prdata | m_paddr | m_pwdata, 0);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer("gpio_rd", 32'h1A10_1004, 32'h0, 1'b0, 0, 32'h0000_00A4, 1'b0);
    xfer("timer_wr", 32'h1A10_3000, 32'hDEAD_BEEF, 1'b1, 4, 32'h1234_5678, 1'b0);
    xfer("unmapped", 32'h1A20_0000, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    xfer("timeout", 32'h1A10_0010, 32'h0, 1'b0, 1000, 32'h0, 1'b0);
    xfer("after_to", 32'h1A10_2020, 32'h0, 1'b0, 1, 32'h5555_0000, 1'b1);
    st[5] = 32'h1A10_4000; en[5] = 32'h1A10_5FFF;
    xfer("overlap", 32'h1A10_4000, 32'h0, 1'b0, 0, 32'hCAFE_0000, 1'b0);
    st = DEF_START; en = DEF_END;
    xfer("b2b_p0", 32'h1A10_0FFF, 32'h0, 1'b0, 0, 32'h0101_0100, 1'b0);
    xfer("b2b_p8", 32'h1A11_7FFF, 32'h0, 1'b0, 0, 32'h0808_0800, 1'b0);
    xfer("edge_lo", 32'h1A0F_FFFF, 32'h0, 1'b1, 0, 32'h0, 1'b0);
    xfer("edge_w7", 32'h1A10_6000, 32'h0, 1'b0, TO - 1, 32'h7777_0000, 1'b0);
    // asynchronous reset during ACCESS
    slv_wait = 1000;
    s_paddr = 32'h1A10_3004; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge HCLK); #1;
    s_penable = 1'b1;
    for (int i = 0; i < 5 && m_penable !== 1'b1; i++) begin @(posedge HCLK); #1; end
    chk("rst_mid.in_access", {m_penable, m_psel}, {1'b1, 9'b0_0000_1000});
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid.dropped", {m_penable, m_psel, s_pready}, 0);
    s_psel = 1'b0; s_penable = 1'b0;
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer("post_rst", 32'h1A10_5100, 32'h0, 1'b0, 2, 32'hA5A5_0000, 1'b0);
    for (int n = 0; n < 25; n++) begin
      int p = $urandom_range(0, 9);
      logic [31:0] a = p == 9 ? 32'h1B00_0000 + $urandom_range(0, 32'hFFFF)
                              : st[p] + $urandom_range(0, 32'hFFF);
      xfer("rand", a, $urandom, 1'($urandom), $urandom_range(0, TO + 2), $urandom,
           1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_node_to.md
Name: apb_node_to

Overview:
- Registered APB 1-to-N demultiplexer with a runtime-programmable address map, unmapped-address error response and per-transfer timeout.
- Sits between the AXI-to-APB bridge (upstream) and the SoC peripherals (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, debug).
- Successor to the combinational peripheral decode: generalised to NB_MASTER ports, with sequential transfer control and bus-hang protection.

Parameters:
- NB_MASTER, 9, number of downstream APB ports.
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout.
- ERR_RDATA, 32'hBADA_CCE5, prdata returned on an error; truncated/zero-extended to APB_DATA_WIDTH.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- s_paddr/s_pwdata/s_pwrite/s_psel/s_penable  in  ADDR/DATA/1/1/1  upstream request.
- s_prdata/s_pready/s_pslverr  out  DATA/1/1  upstream response.
- m_paddr/m_pwdata/m_pwrite  out  ADDR/DATA/1  shared downstream request.
- m_psel  out  NB_MASTER  one-hot downstream select.
- m_penable  out  1  shared downstream enable.
- m_prdata  in  NB_MASTER x DATA  downstream read data.
- m_pready/m_pslverr  in  NB_MASTER  downstream response.
- start_addr_i/end_addr_i  in  NB_MASTER x ADDR  inclusive address ranges, quasi-static.
- timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Clock and reset: single clock HCLK. HRESETn is asynchronous, active-low. All flops clear on reset.
- Reset values: m_psel=0, m_penable=0, s_pready=0, s_pslverr=0, s_prdata=0, m_paddr/m_pwdata/m_pwrite=0, timeout_o=0, state=IDLE, counter=0.
- Address decode: port i hits when start_addr_i[i] <= addr <= end_addr_i[i], unsigned compare. With multiple hits, the lowest index wins.
- IDLE: on s_psel && !s_penable, capture paddr/pwdata/pwrite into the m_* registers and capture the decoded index.
  - Hit -> SETUP.
  - No hit -> RESP with err=1 and rdata=ERR_RDATA.
- SETUP (1 cycle): m_psel[idx]=1, m_penable=0, counter=0. Next state ACCESS.
- ACCESS: m_psel[idx]=1, m_penable=1, counter increments each cycle.
  - m_pready[idx]=1: latch m_prdata[idx] and m_pslverr[idx], drop m_psel/m_penable, go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: drop m_psel/m_penable, latch err=1 and rdata=ERR_RDATA, pulse timeout_o, go to RESP.
  - pready wins over timeout in the same cycle.
- RESP (1 cycle): s_pready=1, s_pslverr=err, s_prdata=latched rdata (writes also return the latched value). Next state IDLE.
- All upstream outputs are registered. s_pready is low in every state except RESP.
- Latency, zero-wait slave: upstream setup at cycle 0, m_psel at cycle 1, m_penable at cycle 2, s_pready at cycle 3. Each slave wait state adds 1 cycle.
- Unmapped access: s_pready at cycle 1.
- Back-to-back: the cycle after RESP is IDLE and accepts a new setup immediately, giving no dead cycle beyond the protocol.
- Upstream protocol violation (s_psel drops mid-transfer): the downstream transfer completes or times out normally. The RESP cycle is still issued and is ignored by the master.
- A late downstream pready after a timeout abort is ignored, since m_psel is already low.
- Reset mid-transfer: all selects and enables drop asynchronously. No response is issued.
- start/end address changes take effect only at the next IDLE capture.

Decomposition:
- Package apb_node_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP}.
  - Default map constants for the SoC: UART 0x1A10_0000..0FFF, GPIO 0x1A10_1000.., up to DEBUG 0x1A11_0000..7FFF.
  - NB_MASTER default.
- Sub-module apb_addr_dec: combinational, parametrised on NB_MASTER and ADDR width. Outputs a one-hot hit vector, a hit flag and an encoded index with lowest-index priority.

Test Plan:
- Read 0x1A10_1004 with GPIO (port 1) returning 0x0000_00A5 and pready at first ACCESS -> m_psel=9'b000000010 for 2 cycles; s_pready at cycle 3 with s_prdata=0xA5, s_pslverr=0.
- Write 0xDEAD_BEEF to 0x1A10_3000 with timer (port 3) holding pready low for 4 cycles -> m_pwdata stable throughout; s_pready at cycle 7, s_pslverr=0.
- Read unmapped 0x1A20_0000 -> no m_psel asserted; s_pready at cycle 1, s_pslverr=1, s_prdata=0xBADA_CCE5.
- TIMEOUT_CYCLES=8, port 0 never ready -> m_psel drops after 8 ACCESS cycles; timeout_o pulses once; s_pslverr=1. A subsequent access to port 2 completes normally.
- Overlapping ranges for ports 4 and 5 covering 0x1A10_4000 -> only m_psel[4] asserted. Back-to-back reads to ports 0 and 8 -> second setup accepted the cycle after the first RESP.
- HRESETn asserted during ACCESS -> m_psel, m_penable and s_pready are 0 immediately. After release, the state is IDLE and the next transfer behaves normally.
